// File: rtl/systolic_nxn_ws.sv
// rtl/systolic_nxn_ws.sv - N x N weight-stationary systolic matrix-vector engine
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module systolic_nxn_ws #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  input  logic [$clog2(N)-1:0]  w_row,
  input  logic [N*DW-1:0]       w_data,
  input  logic                  w_last,
  input  logic                  start,
  input  logic                  a_valid,
  input  logic [N*DW-1:0]       a_data,
  input  logic                  a_last,
  output logic                  a_ready,
  output logic                  c_valid,
  output logic [N*AW-1:0]       c_data,
  output logic                  c_last,
  output logic                  busy
);
  localparam int L  = 2 * N;
  localparam int CW = $clog2(L);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]                 drain_cnt;
  logic                          accept;
  logic                          w_we;
  logic [L-1:0]                  tag_v;
  logic [L-1:0]                  tag_l;
  logic [N-1:0][N-1:0][DW-1:0]   wgt;
  logic [N-1:0][N-1:0][DW-1:0]   a_h;
  logic [N:0][N-1:0][AW-1:0]     p_v;
  logic [N-1:0][AW-1:0]          col_out;

  assign accept = a_valid && (state == RUN);
  assign w_we   = w_valid && (state == IDLE || state == LOAD) && (32'(w_row) < 32'(N));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (w_valid) state_nxt = LOAD;
             else if (start) state_nxt = RUN;
      LOAD:  if (w_valid && w_last) state_nxt = RUN;
      RUN:   if (accept && a_last) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == CW'(L - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ready = (state == RUN);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) drain_cnt <= '0;
    else                       drain_cnt <= drain_cnt + 1'b1;
  end

  // Out-of-range rows are dropped; unwritten rows keep their previous weights.
  always_ff @(posedge clk) begin
    if (rst)       wgt        <= '0;
    else if (w_we) wgt[w_row] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v   <= '0;
      tag_l   <= '0;
      c_valid <= 1'b0;
      c_last  <= 1'b0;
      c_data  <= '0;
    end else begin
      tag_v   <= {tag_v[L-2:0], accept};
      tag_l   <= {tag_l[L-2:0], accept && a_last};
      c_valid <= tag_v[L-1];
      c_last  <= tag_l[L-1];
      if (tag_v[L-1]) c_data <= col_out;
    end
  end

  // Row k sees a[k] after the shared input register plus k skew stages.
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic [DW-1:0] sk [0:k];
    always_ff @(posedge clk) begin
      sk[0] <= a_data[k*DW +: DW];
      for (int d = 1; d <= k; d++) sk[d] <= sk[d-1];
    end
    assign a_h[k][0] = sk[k];
  end

  for (genvar j = 0; j < N; j++) begin : g_top
    assign p_v[0][j] = '0;
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [2*DW-1:0] prod;
      logic [AW-1:0]   prod_ext;
      logic [AW-1:0]   psum_q;
`ifdef SYSTOLIC_SIGNED_EN
      assign prod     = {{DW{a_h[k][j][DW-1]}}, a_h[k][j]} * {{DW{wgt[k][j][DW-1]}}, wgt[k][j]};
      assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
`else
      assign prod     = {{DW{1'b0}}, a_h[k][j]} * {{DW{1'b0}}, wgt[k][j]};
      assign prod_ext = {{(AW-2*DW){1'b0}}, prod};
`endif
      always_ff @(posedge clk) psum_q <= p_v[k][j] + prod_ext;
      assign p_v[k+1][j] = psum_q;

      if (j < N - 1) begin : g_fwd
        logic [DW-1:0] a_q;
        always_ff @(posedge clk) a_q <= a_h[k][j];
        assign a_h[k][j+1] = a_q;
      end
    end
  end

  // Column j leaves the array j cycles late; pad it so all columns align.
  for (genvar j = 0; j < N; j++) begin : g_desk
    if (j == N - 1) begin : g_pass
      assign col_out[j] = p_v[N][j];
    end else begin : g_dly
      logic [AW-1:0] dq [0:N-2-j];
      always_ff @(posedge clk) begin
        dq[0] <= p_v[N][j];
        for (int d = 1; d <= N - 2 - j; d++) dq[d] <= dq[d-1];
      end
      assign col_out[j] = dq[N-2-j];
    end
  end
endmodule

// File: tb/tb_systolic_nxn_ws.sv
// tb/tb_systolic_nxn_ws.sv - directed self-checking bench for systolic_nxn_ws
module tb_systolic_nxn_ws;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              w_valid = 1'b0;
  logic [1:0]        w_row = '0;
  logic [N*DW-1:0]   w_data = '0;
  logic              w_last = 1'b0;
  logic              start = 1'b0;
  logic              a_valid = 1'b0;
  logic [N*DW-1:0]   a_data = '0;
  logic              a_last = 1'b0;
  logic              a_ready;
  logic              c_valid;
  logic [N*AW-1:0]   c_data;
  logic              c_last;
  logic              busy;

  systolic_nxn_ws #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_row(w_row), .w_data(w_data), .w_last(w_last),
    .start(start),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .c_valid(c_valid), .c_data(c_data), .c_last(c_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               q_cyc  [$];
  logic [N*AW-1:0]  q_data [$];
  logic             q_last [$];
  logic             q_busy [$];

  always @(negedge clk) begin
    if (c_valid) begin
      q_cyc.push_back(cyc);
      q_data.push_back(c_data);
      q_last.push_back(c_last);
      q_busy.push_back(busy);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] vec(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                          input logic [DW-1:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [N*AW-1:0] pk(input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                                         input logic [AW-1:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic load3(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                       input logic [N*DW-1:0] r2);
    w_valid = 1'b1; w_row = 2'd0; w_data = r0; sync();
    w_row = 2'd1; w_data = r1; sync();
    w_row = 2'd2; w_data = r2; w_last = 1'b1; sync();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic send(input logic [N*DW-1:0] a, input logic last, output int acc);
    a_valid = 1'b1; a_data = a; a_last = last;
    acc = cyc + 1;
    sync();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; sync(); start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [N*AW-1:0] exp, input logic exp_last,
                            input int acc, output logic b);
    int n = 0;
    b = 1'bx;
    while (q_data.size() == 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q_data.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_data"}, 64'(q_data.pop_front()), 64'(exp));
      check({tag, "_last"}, 64'(q_last.pop_front()), 64'(exp_last));
      check({tag, "_lat"}, 64'(q_cyc.pop_front() - acc), 64'd6);
      b = q_busy.pop_front();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int   a1, a2, a3, a4, acc;
  logic b;
  logic ready_seen;

  initial begin
    rst = 1'b1;
    sync(); sync();
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_c_valid", 64'(c_valid), 64'd0);
    check("rst_c_last",  64'(c_last),  64'd0);
    check("rst_c_data",  64'(c_data),  64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    rst = 1'b0;

    // a_valid without load or start must be ignored
    ready_seen = 1'b0;
    a_valid = 1'b1; a_data = vec(8'd1, 8'd1, 8'd1);
    repeat (8) begin
      sync();
      if (a_ready) ready_seen = 1'b1;
    end
    a_valid = 1'b0;
    repeat (10) sync();
    check("idle_ready",  64'(ready_seen), 64'd0);
    check("idle_no_out", 64'(q_data.size()), 64'd0);

`ifdef SYSTOLIC_SIGNED_EN
    load3(vec(8'h80, 8'h80, 8'h80), vec(8'h80, 8'h80, 8'h80), vec(8'h80, 8'h80, 8'h80));
    send(vec(8'h80, 8'h80, 8'h80), 1'b1, acc);
    expect_out("sneg_neg", pk(20'd49152, 20'd49152, 20'd49152), 1'b1, acc, b);
    sync();
    load3(vec(8'h7F, 8'h7F, 8'h7F), vec(8'h7F, 8'h7F, 8'h7F), vec(8'h7F, 8'h7F, 8'h7F));
    send(vec(8'h80, 8'h80, 8'h80), 1'b1, acc);
    expect_out("sneg_pos", pk(20'hF4180, 20'hF4180, 20'hF4180), 1'b1, acc, b);
    sync();
`else
    load3(vec(8'hFF, 8'hFF, 8'hFF), vec(8'hFF, 8'hFF, 8'hFF), vec(8'hFF, 8'hFF, 8'hFF));
    check("load_run_ready", 64'(a_ready), 64'd1);
    send(vec(8'hFF, 8'hFF, 8'hFF), 1'b1, acc);
    expect_out("umax", pk(20'd195075, 20'd195075, 20'd195075), 1'b1, acc, b);
    sync();
`endif

    load3(vec(8'd1, 8'd2, 8'd3), vec(8'd4, 8'd5, 8'd6), vec(8'd7, 8'd8, 8'd9));
    check("load_busy", 64'(busy), 64'd1);
    send(vec(8'd1, 8'd1, 8'd1), 1'b1, acc);
    check("drain_busy", 64'(busy), 64'd1);
    expect_out("single", pk(20'd12, 20'd15, 20'd18), 1'b1, acc, b);
    check("single_busy_at_last", 64'(b), 64'd0);
    sync();

    // back-to-back stream with one bubble after the second vector
    go();
    send(vec(8'd1, 8'd0, 8'd0), 1'b0, a1);
    send(vec(8'd0, 8'd1, 8'd0), 1'b0, a2);
    sync();
    send(vec(8'd0, 8'd0, 8'd1), 1'b0, a3);
    send(vec(8'd2, 8'd2, 8'd2), 1'b1, a4);
    expect_out("s1", pk(20'd1, 20'd2, 20'd3), 1'b0, a1, b);
    expect_out("s2", pk(20'd4, 20'd5, 20'd6), 1'b0, a2, b);
    expect_out("s3", pk(20'd7, 20'd8, 20'd9), 1'b0, a3, b);
    expect_out("s4", pk(20'd24, 20'd30, 20'd36), 1'b1, a4, b);
    check("s_gap", 64'(a3 - a2), 64'd2);
    repeat (4) sync();
    check("s_no_extra", 64'(q_data.size()), 64'd0);

    // out-of-range row writes change nothing, but w_last still moves to RUN
    w_valid = 1'b1; w_row = 2'd3; w_data = '0; sync();
    w_last = 1'b1; sync();
    w_valid = 1'b0; w_last = 1'b0;
    check("row3_run", 64'(a_ready), 64'd1);
    send(vec(8'd1, 8'd1, 8'd1), 1'b1, acc);
    expect_out("row3", pk(20'd12, 20'd15, 20'd18), 1'b1, acc, b);
    sync();
    go();
    check("reuse_run", 64'(a_ready), 64'd1);
    send(vec(8'd1, 8'd1, 8'd1), 1'b1, acc);
    expect_out("reuse", pk(20'd12, 20'd15, 20'd18), 1'b1, acc, b);
    sync();

    // reset three cycles into DRAIN
    go();
    send(vec(8'd1, 8'd1, 8'd1), 1'b1, acc);
    sync(); sync();
    rst = 1'b1; sync(); rst = 1'b0;
    check("mid_rst_busy",  64'(busy),    64'd0);
    check("mid_rst_ready", 64'(a_ready), 64'd0);
    repeat (12) sync();
    check("mid_rst_no_out", 64'(q_data.size()), 64'd0);
    go();
    send(vec(8'd1, 8'd1, 8'd1), 1'b1, acc);
    expect_out("after_rst", pk(20'd0, 20'd0, 20'd0), 1'b1, acc, b);
    repeat (3) sync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_nxn_ws.md
# systolic_nxn_ws

Parametrised N×N weight-stationary systolic matrix-vector engine. It computes one output row C = A_row × W per accepted input vector, with full throughput of one vector per cycle. Weights are loaded once through a row-write port and stay resident across batches. Input skewing, output de-skewing and valid/last tagging are internal, so the block sits directly between an activation streamer and a result collector with no external cycle bookkeeping.

## Interface
- N, 3: array dimension (rows = input elements k, columns = outputs j); N ≥ 2
- DW, 8: operand width (activations and weights)
- AW, 20: accumulator/output element width; must be ≥ 2*DW + clog2(N)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- w_valid  in  1  weight row write strobe
- w_row  in  clog2(N)  row index k being written
- w_data  in  N*DW  W[k][j] at bits [j*DW +: DW]
- w_last  in  1  marks the final weight row of a load
- start  in  1  IDLE→RUN reusing resident weights
- a_valid  in  1  input vector valid
- a_data  in  N*DW  element a[k] at bits [k*DW +: DW]
- a_last  in  1  marks the final vector of a batch
- a_ready  out  1  high only in RUN
- c_valid  out  1  result valid (single-cycle, no backpressure)
- c_data  out  N*AW  c[j] at bits [j*AW +: AW]
- c_last  out  1  accompanies the result of the a_last vector
- busy  out  1  high in LOAD, RUN, DRAIN

## Operation
- c[j] = Σ_k a[k]·W[k][j]. Products are 2*DW wide and zero-extended to AW; sums wrap modulo 2^AW.
- PE(k,j) holds W[k][j]. Each cycle it registers a rightward and adds a·W to the partial sum from above, registering the result downward. Row 0 receives partial sum 0.
- Input skew: a[k] is delayed k cycles. Output de-skew: column j is delayed N-1-j cycles, then passes through one output register.
- A valid/last tag travels the pipeline with each vector. Bubbles (a_valid low in RUN) propagate as c_valid low in the same pattern.
- FSM:
  - IDLE: w_valid→LOAD (the row is written). start→RUN. w_valid has priority over start.
  - LOAD: each w_valid writes row w_row. w_valid with w_last→RUN. w_row ≥ N is ignored, but its w_last still takes effect.
  - RUN: a vector is accepted when a_valid and a_ready are both high. An accepted vector with a_last→DRAIN. w_valid and start are ignored.
  - DRAIN: counts L cycles, then enters IDLE on the cycle that c_last is emitted.
- Weights persist until overwritten or reset. Rows not written during a LOAD keep their old values.

## Timing
- Latency L = 2N cycles: a vector accepted at edge t produces c_valid high for the cycle following edge t+2N. For N=3, L=6.
- Throughput is one vector per cycle in RUN.
- A weight row written at edge t is used by any vector accepted at or after edge t+1.
- Reset values: a_ready=0, c_valid=0, c_last=0, c_data=0, busy=0, all weights 0, all pipeline tags cleared, state IDLE.
- Reset mid-operation: results in flight are discarded, and no c_valid follows the reset edge.
- a_valid in IDLE, LOAD or DRAIN is ignored.

## Configuration
- SYSTOLIC_SIGNED_EN defined: activations and weights are two's complement. Products are sign-extended to AW, and c[j] is a signed AW-bit value.
- SYSTOLIC_SIGNED_EN undefined: all operands are unsigned, with zero extension.

## Test plan
- Reset: drive rst for 2 cycles → all outputs 0. Then a_valid=1 with no load → a_ready stays 0 and c_valid never rises.
- Load W rows [1,2,3],[4,5,6],[7,8,9] (N=3); send a=[1,1,1] with a_last → c=[12,15,18] exactly 6 cycles after acceptance, with c_last=1. busy drops on the same cycle as c_last.
- 4 back-to-back vectors [1,0,0],[0,1,0],[0,0,1],[2,2,2] with a one-cycle bubble after the 2nd → outputs [1,2,3],[4,5,6],(bubble),[7,8,9],[24,30,36] in that exact order.
- Unsigned extremes: all a=255, all W=255 → every c[j]=195075. With SYSTOLIC_SIGNED_EN: all a=0x80, all W=0x80 → c=49152; all a=0x80, all W=0x7F → c=-48768.
- Load with a w_row=3 write → no weight changes. Then start after IDLE → prior weights are reused and identical results are produced.
- Assert rst 3 cycles into DRAIN → no c_valid afterward; state IDLE and weights 0 (a=[1,1,1] after start gives c=[0,0,0]).
